down_count_checker: RTL and testbench
=====================================

Name: down_count_checker

Overview:
- Sequential monitor placed directly downstream of the 4-bit free-running down counter.
- Samples the counter's output every clock and checks that each new value is exactly the previous value minus one, modulo 2^WIDTH.
- Counts underflow wraps (0 -> all-ones) and flags broken sequences.
- Gives the system a registered wrap tick plus sticky error status.

Parameters:
- WIDTH, 4: width of the monitored count bus.
- WRAP_CNT_W, 8: width of the saturating wrap counter.
- ERR_CNT_W, 4: width of the saturating error counter.
- RESYNC_LEN, 3: consecutive good steps needed to leave ERROR. Used only when the optional feature is compiled in. Range 1..15.

Ports:
- clock, input, 1: single system clock, rising edge.
- reset_L, input, 1: asynchronous active-low reset.
- count_in, input, WIDTH: count value from the upstream down counter.
- clear, input, 1: synchronous clear of status, counters and FSM.
- in_sync, output, 1: high while the FSM is in TRACK.
- wrap_pulse, output, 1: one-cycle pulse per detected 0 -> all-ones step.
- wrap_count, output, WRAP_CNT_W: number of wraps detected; saturates at all-ones.
- err_flag, output, 1: sticky; set on first sequence error.
- err_count, output, ERR_CNT_W: number of TRACK -> ERROR entries; saturates.

Behaviour:
- Clocking and reset: one clock domain, clock. reset_L is asynchronous, active-low.
- Reset values:
  - FSM = IDLE, prev = 0.
  - in_sync = 0, wrap_pulse = 0, wrap_count = 0, err_flag = 0, err_count = 0.
- Timing:
  - All outputs are registered.
  - count_in is sampled at edge k and compared against prev, which was captured at edge k-1.
  - Results are visible after edge k, i.e. latency is 1 cycle from sample to flag.
- prev register: loads count_in on every edge while not in reset.
- expected = (prev - 1) mod 2^WIDTH, so 0 maps to 2^WIDTH-1.
- wrap_pulse defaults to 0 every cycle and is high for exactly one cycle per wrap.
- FSM:
  - IDLE:
    - First edge captures prev; no comparison is made.
    - Next state is TRACK.
  - TRACK:
    - count_in == expected: good step.
    - If the good step has prev == 0 (i.e. count_in all-ones): wrap_pulse = 1 and wrap_count += 1, saturating.
    - count_in != expected: err_flag = 1, err_count += 1 (saturating), next state ERROR, no wrap counted.
    - A held (unchanged) value counts as an error.
  - ERROR:
    - No wrap counting; wrap_pulse = 0.
    - err_count does not increment further.
    - Exit only via clear, reset, or the optional resync.
- clear (synchronous):
  - Next state IDLE.
  - wrap_count = 0, err_count = 0, err_flag = 0, wrap_pulse = 0.
  - prev still loads count_in.
- Simultaneous events:
  - clear has priority over error detection and wrap detection in the same cycle.
  - reset_L overrides everything asynchronously.
- Reset mid-stream: the FSM returns to IDLE, so the first post-reset sample is never compared. The upstream counter's reset value (1) therefore causes no false error.
- Saturation: wrap_count and err_count stick at all-ones and do not roll over. A wrap at saturation still pulses wrap_pulse.
- in_sync = (state == TRACK), registered.

Optional Feature:
- Macro: DOWN_COUNT_CHECKER_RESYNC_EN.
- When defined:
  - ERROR keeps a good-step run counter, cleared on entry to ERROR.
  - Each step with count_in == expected increments the run counter; any mismatch zeroes it.
  - When the run reaches RESYNC_LEN, next state is TRACK.
  - A good step that is also a wrap is not counted as a wrap during the resync window.
  - err_flag stays sticky; err_count increments again on the next TRACK -> ERROR entry.
- When not defined: ERROR is terminal until clear or reset. No run counter logic is present.

Test Plan:
- Reset release, then count_in stream 1,0,F,E,D -> in_sync = 1 after the 2nd edge. wrap_pulse is high exactly one cycle, after F is sampled. wrap_count = 1, err_flag = 0.
- Free-run 40 cycles from 1 -> wrap_count = 3, wrap_pulse high 3 single cycles, err_flag = 0.
- Stream 9,8,8,7 -> err_flag = 1 after the second 8 is sampled. err_count = 1, in_sync = 0. Without the macro, in_sync stays 0 for the rest of the stream.
- Error then clear asserted in the same cycle as another mismatch (5,3 with clear on 3) -> state IDLE, err_flag = 0, err_count = 0. After 2 good steps, in_sync = 1.
- Preload wrap_count to saturation (WRAP_CNT_W = 2, 5 wraps) -> wrap_count holds 3, wrap_pulse still fires on each wrap.
- With DOWN_COUNT_CHECKER_RESYNC_EN and RESYNC_LEN = 3:
  - Stream 6,4,3,2,1 -> ERROR after 4, in_sync = 1 after 1 is sampled, err_flag stays 1, err_count = 1.
  - Assert reset_L low mid-stream -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/down_count_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : down_count_checker
// Description : Monitors a free-running down counter. Each new sample must
//               equal the previous sample minus one (mod 2^WIDTH). Counts
//               underflow wraps, flags broken sequences and keeps sticky
//               error status. All outputs are registered.
//               Optional macro DOWN_COUNT_CHECKER_RESYNC_EN lets the checker
//               return from ERROR to TRACK after RESYNC_LEN good steps.
// Revision    : 1.0 - initial release
// ============================================================================
module down_count_checker #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8,
  parameter int ERR_CNT_W  = 4,
  parameter int RESYNC_LEN = 3
) (
  input  logic                  clock,
  input  logic                  reset_L,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clear,
  output logic                  in_sync,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  err_flag,
  output logic [ERR_CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  // The run counter is 4 bits wide, so the resync length must fit in it.
  if (RESYNC_LEN < 1 || RESYNC_LEN > 15) begin : g_resync_len_check
    $error("down_count_checker: RESYNC_LEN must be in 1..15");
  end

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic                  in_sync_q, in_sync_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic                  err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic [WIDTH-1:0]      expected;
  logic                  step_ok;
  logic                  wrap_step;

`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
  logic [3:0]            run_q, run_d;
`endif

  // Next-state and output computation; clear overrides every detection path.
  always_comb begin
    state_d      = state_q;
    prev_d       = count_in;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;
    err_flag_d   = err_flag_q;
    err_count_d  = err_count_q;
`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
    run_d        = run_q;
`endif

    expected  = prev_q - {{(WIDTH-1){1'b0}}, 1'b1};
    step_ok   = (count_in == expected);
    wrap_step = (prev_q == '0);

    if (clear) begin
      state_d      = ST_IDLE;
      wrap_count_d = '0;
      err_count_d  = '0;
      err_flag_d   = 1'b0;
`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
      run_d        = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // First sample only seeds prev; there is nothing to compare yet.
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (step_ok) begin
            if (wrap_step) begin
              wrap_pulse_d = 1'b1;
              if (wrap_count_q != '1) begin
                wrap_count_d = wrap_count_q + 1'b1;
              end
            end
          end else begin
            state_d    = ST_ERROR;
            err_flag_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
            run_d = '0;
`endif
          end
        end
        ST_ERROR: begin
`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
          // Wraps inside the resync window are deliberately not counted.
          if (step_ok) begin
            run_d = run_q + 4'd1;
            if (run_d == 4'(RESYNC_LEN)) begin
              state_d = ST_TRACK;
              run_d   = '0;
            end
          end else begin
            run_d = '0;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    in_sync_d = (state_d == ST_TRACK);
  end

  // State and status registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      in_sync_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      in_sync_q    <= in_sync_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
    end
  end

`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
  // Good-step run counter used to leave ERROR.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end
`endif

  assign in_sync    = in_sync_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_down_count_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_down_count_checker
// Description : Self-checking bench for down_count_checker. Directed streams
//               plus randomized down-count traffic with glitches, clears and
//               asynchronous resets, compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_count_checker;

  localparam int WIDTH      = 4;
  localparam int WRAP_CNT_W = 8;
  localparam int ERR_CNT_W  = 4;
  localparam int RESYNC_LEN = 3;
  localparam int MOD        = 1 << WIDTH;
  localparam int WRAP_MAX   = (1 << WRAP_CNT_W) - 1;
  localparam int ERR_MAX    = (1 << ERR_CNT_W) - 1;

  logic                  clock = 1'b0;
  logic                  reset_L;
  logic [WIDTH-1:0]      count_in;
  logic                  clear;
  logic                  in_sync;
  logic                  wrap_pulse;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic                  err_flag;
  logic [ERR_CNT_W-1:0]  err_count;

  down_count_checker #(
    .WIDTH      (WIDTH),
    .WRAP_CNT_W (WRAP_CNT_W),
    .ERR_CNT_W  (ERR_CNT_W),
    .RESYNC_LEN (RESYNC_LEN)
  ) dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .count_in   (count_in),
    .clear      (clear),
    .in_sync    (in_sync),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_flag   (err_flag),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: tracks whether a baseline exists, whether the
  // sequence is currently broken, and the counts the spec asks for.
  int m_prev;
  bit m_started;
  bit m_broken;
  int m_run;
  int m_wraps;
  int m_errs;
  bit m_sticky;
  bit m_pulse;

  task automatic model_reset();
    m_prev = 0; m_started = 0; m_broken = 0; m_run = 0;
    m_wraps = 0; m_errs = 0; m_sticky = 0; m_pulse = 0;
  endtask

  task automatic model_edge(input int c, input bit clr);
    int exp_v;
    exp_v   = (m_prev + MOD - 1) % MOD;
    m_pulse = 0;
    if (clr) begin
      m_started = 0; m_broken = 0; m_run = 0;
      m_wraps = 0; m_errs = 0; m_sticky = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (!m_broken) begin
      if (c == exp_v) begin
        if (m_prev == 0) begin
          m_pulse = 1;
          if (m_wraps < WRAP_MAX) m_wraps++;
        end
      end else begin
        m_sticky = 1;
        if (m_errs < ERR_MAX) m_errs++;
        m_broken = 1;
        m_run    = 0;
      end
    end else begin
`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
      if (c == exp_v) begin
        m_run++;
        if (m_run >= RESYNC_LEN) begin
          m_broken = 0;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
`endif
    end
    m_prev = c;
  endtask

  task automatic check_all();
    check("in_sync",    32'(in_sync),    32'(m_started && !m_broken));
    check("wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
    check("wrap_count", 32'(wrap_count), 32'(m_wraps));
    check("err_flag",   32'(err_flag),   32'(m_sticky));
    check("err_count",  32'(err_count),  32'(m_errs));
  endtask

  int pulses_seen;

  // Drive one sample, let the edge happen, then compare just after it.
  task automatic step(input int c, input bit clr);
    int cv;
    cv       = c % MOD;
    count_in = cv[WIDTH-1:0];
    clear    = clr;
    @(posedge clock);
    model_edge(cv, clr);
    #1;
    if (wrap_pulse) pulses_seen++;
    check_all();
  endtask

  // Asynchronous reset away from any clock edge; outputs must drop at once.
  task automatic do_reset();
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all();
    #3;
    reset_L = 1'b1;
  endtask

  initial begin
    int cur;
    reset_L  = 1'b0;
    clear    = 1'b0;
    count_in = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset_L = 1'b1;

    // Basic stream through a wrap.
    step(1, 0); step(0, 0); step(15, 0);
    check("wrap_on_F", 32'(wrap_pulse), 32'd1);
    step(14, 0);
    check("pulse_one_cycle", 32'(wrap_pulse), 32'd0);
    step(13, 0);
    check("in_sync_stream", 32'(in_sync), 32'd1);

    // Free run of 40 samples from 1: three wraps.
    do_reset();
    pulses_seen = 0;
    for (int i = 0; i < 40; i++) step(1 - i + 4 * MOD, 0);
    check("freerun_pulses", 32'(pulses_seen), 32'd3);
    check("freerun_wraps", 32'(wrap_count), 32'd3);

    // Held value is an error.
    do_reset();
    step(9, 0); step(8, 0); step(8, 0);
    check("held_err_flag", 32'(err_flag), 32'd1);
    check("held_err_count", 32'(err_count), 32'd1);
    check("held_in_sync", 32'(in_sync), 32'd0);
    step(7, 0); step(6, 0); step(5, 0);

    // Clear wins over a simultaneous mismatch.
    do_reset();
    step(7, 0); step(5, 0); step(3, 1);
    check("clear_err_flag", 32'(err_flag), 32'd0);
    check("clear_in_sync", 32'(in_sync), 32'd0);
    step(2, 0); step(1, 0); step(0, 0);
    check("clear_resume", 32'(in_sync), 32'd1);

    // Resync window (terminal ERROR without the macro).
    do_reset();
    step(6, 0); step(4, 0); step(3, 0); step(2, 0); step(1, 0);
`ifdef DOWN_COUNT_CHECKER_RESYNC_EN
    check("resync_in_sync", 32'(in_sync), 32'd1);
`else
    check("resync_in_sync", 32'(in_sync), 32'd0);
`endif
    step(0, 0); step(15, 0); step(14, 0);
    step(9, 0); step(8, 0);

    // Mid-stream reset, then first sample (1) must not be compared.
    do_reset();
    step(1, 0); step(0, 0);
    check("post_reset_err", 32'(err_flag), 32'd0);

    // Saturation of the wrap counter: 260 wraps.
    do_reset();
    pulses_seen = 0;
    for (int i = 0; i < 260 * MOD; i++) step((1 - i) % MOD + MOD, 0);
    check("sat_wraps", 32'(wrap_count), 32'(WRAP_MAX));
    check("sat_pulses", 32'(pulses_seen), 32'd260);

    // Randomized traffic: mostly clean down counting with glitches,
    // clears and asynchronous resets sprinkled in.
    do_reset();
    cur = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 5) begin
        do_reset();
        cur = 1;
      end else begin
        if (r < 60) cur = int'($urandom_range(0, MOD - 1));
        else if (r < 80) cur = cur;
        else cur = (cur + MOD - 1) % MOD;
        step(cur, $urandom_range(0, 99) < 2);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on simulated time so the bench always terminates.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
